// File: rtl/md_pkg.sv
// Shared MD datapath types: packed 3-axis float force and
// helpers for recognising zero-magnitude axes.
package md_pkg;

  localparam int AXIS_W   = 32;
  localparam int VEC_W    = 3 * AXIS_W;
  localparam int X_OFF    = 0;
  localparam int Y_OFF    = 32;
  localparam int Z_OFF    = 64;
  localparam int SIGN_BIT = 31;

  typedef logic [VEC_W-1:0] vec3_t;

  typedef enum logic [1:0] {
    IDLE,
    EMIT_REF,
    EMIT_NBR
  } state_t;

  // +0 and -0 both count as zero magnitude
  function automatic logic zero_mag(
    input logic [AXIS_W-1:0] a
  );
    return a[SIGN_BIT-1:0] == '0;
  endfunction

  function automatic logic vec_zero(
    input vec3_t v
  );
    return zero_mag(v[X_OFF +: AXIS_W])
        && zero_mag(v[Y_OFF +: AXIS_W])
        && zero_mag(v[Z_OFF +: AXIS_W]);
  endfunction

endpackage

// File: rtl/pair_fifo.sv
// Small pair-record FIFO exposing the head and the entry
// behind it so the emitter can chain pairs without bubbles.
module pair_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 128
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             head,
  output logic [W-1:0]             nxt,
  output logic [$clog2(DEPTH):0]   cnt,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   wp;
  logic [AW:0]   rp;
  logic [AW-1:0] ra1;

  assign ra1   = rp[AW-1:0] + AW'(1);
  assign head  = mem[rp[AW-1:0]];
  assign nxt   = mem[ra1];
  assign cnt   = wp - rp;
  assign full  = cnt == (AW+1)'(DEPTH);
  assign empty = wp == rp;

  // read/write pointers with wrap bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + (AW+1)'(1);
      if (pop)  rp <= rp + (AW+1)'(1);
    end
  end

  // storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (push) begin
      mem[wp[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/n3l_reaction.sv
// Newton-third-law expander: each pair record becomes a
// reference write and a sign-flipped neighbor write.
module n3l_reaction
  import md_pkg::*;
#(
  parameter int ID_W  = 16,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ID_W-1:0] in_ref_id,
  input  logic [ID_W-1:0] in_nbr_id,
  input  vec3_t           in_force,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ID_W-1:0] out_id,
  output vec3_t           out_force,
  output logic            out_is_nbr,
  output logic [31:0]     pair_cnt,
  output logic [31:0]     drop_cnt
);

  localparam int PW = 2*ID_W + VEC_W;
  localparam int CW = $clog2(DEPTH) + 1;

  logic            rdy_en;
  logic            push;
  logic            pop;
  logic            drop;
  logic            hs;
  logic            full;
  logic            empty;
  logic            has_nxt;
  logic            h_drop;
  logic            n_drop;
  logic [PW-1:0]   din;
  logic [PW-1:0]   head;
  logic [PW-1:0]   nxt;
  logic [CW-1:0]   cnt;
  logic [ID_W-1:0] h_ref;
  logic [ID_W-1:0] h_nbr;
  logic [ID_W-1:0] n_ref;
  logic [ID_W-1:0] n_nbr;
  vec3_t           h_f;
  vec3_t           n_f;
  state_t          state;

  // zero axes go out as +0; neighbor copy flips the sign
  function automatic logic [AXIS_W-1:0] ax(
    input logic [AXIS_W-1:0] a,
    input logic              neg
  );
    if (zero_mag(a))
      return '0;
    return {a[SIGN_BIT] ^ neg, a[SIGN_BIT-1:0]};
  endfunction

  function automatic vec3_t fmt(
    input vec3_t v,
    input logic  neg
  );
    vec3_t r;
    r[X_OFF +: AXIS_W] = ax(v[X_OFF +: AXIS_W], neg);
    r[Y_OFF +: AXIS_W] = ax(v[Y_OFF +: AXIS_W], neg);
    r[Z_OFF +: AXIS_W] = ax(v[Z_OFF +: AXIS_W], neg);
    return r;
  endfunction

  assign din = {in_ref_id, in_nbr_id, in_force};
  assign {h_ref, h_nbr, h_f} = head;
  assign {n_ref, n_nbr, n_f} = nxt;

  assign h_drop  = (h_ref == h_nbr) || vec_zero(h_f);
  assign n_drop  = (n_ref == n_nbr) || vec_zero(n_f);
  assign has_nxt = cnt > CW'(1);

  assign in_ready = rdy_en & ~full;
  assign push     = in_valid & in_ready;
  assign hs       = out_valid & out_ready;
  assign drop     = (state == IDLE) & ~empty & h_drop;
  assign pop      = drop | ((state == EMIT_NBR) & hs);

  pair_fifo #(
    .DEPTH (DEPTH),
    .W     (PW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .head  (head),
    .nxt   (nxt),
    .cnt   (cnt),
    .full  (full),
    .empty (empty)
  );

  // hold in_ready low until the first edge out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  // emit FSM with registered output write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_id     <= '0;
      out_force  <= '0;
      out_is_nbr <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty && !h_drop) begin
            state      <= EMIT_REF;
            out_valid  <= 1'b1;
            out_id     <= h_ref;
            out_force  <= fmt(h_f, 1'b0);
            out_is_nbr <= 1'b0;
          end
        end
        EMIT_REF: begin
          if (hs) begin
            state      <= EMIT_NBR;
            out_id     <= h_nbr;
            out_force  <= fmt(h_f, 1'b1);
            out_is_nbr <= 1'b1;
          end
        end
        EMIT_NBR: begin
          if (hs) begin
            if (has_nxt && !n_drop) begin
              state      <= EMIT_REF;
              out_id     <= n_ref;
              out_force  <= fmt(n_f, 1'b0);
              out_is_nbr <= 1'b0;
            end else begin
              state     <= IDLE;
              out_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // completed and discarded pair counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if ((state == EMIT_NBR) && hs) pair_cnt <= pair_cnt + 32'd1;
      if (drop)                      drop_cnt <= drop_cnt + 32'd1;
    end
  end

endmodule

// File: doc/n3l_reaction.md
N3L_REACTION -- requirements
Module: n3l_reaction

Interface
REQ-001 Parameter ID_W, default 16, width of particle identifiers.
REQ-002 Parameter DEPTH, default 4, input FIFO entries (power of two, >=2).
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  pair-force record offered.
REQ-006 in_ready  output  1  record accepted when in_valid&&in_ready at clk edge.
REQ-007 in_ref_id  input  ID_W  reference particle id.
REQ-008 in_nbr_id  input  ID_W  neighbor particle id.
REQ-009 in_force  input  96  force on reference, IEEE-754 single per axis: x=[31:0], y=[63:32], z=[95:64].
REQ-010 out_valid  output  1  accumulate-write offered.
REQ-011 out_ready  input  1  write taken when out_valid&&out_ready at clk edge.
REQ-012 out_id  output  ID_W  particle to accumulate into.
REQ-013 out_force  output  96  force to add, same packing as in_force.
REQ-014 out_is_nbr  output  1  0 = reference write, 1 = neighbor (reaction) write.
REQ-015 pair_cnt  output  32  pairs fully emitted since reset.
REQ-016 drop_cnt  output  32  pairs discarded since reset.

Function
REQ-017 Accepted records SHALL enter a DEPTH-entry FIFO; in_ready SHALL equal "FIFO not full", independent of in_valid.
REQ-018 FSM states IDLE, EMIT_REF, EMIT_NBR; IDLE->EMIT_REF when FIFO non-empty and head not dropped; EMIT_REF->EMIT_NBR on out handshake; EMIT_NBR->EMIT_REF on handshake if next head exists and is not dropped, else ->IDLE.
REQ-019 Head pops from FIFO on the EMIT_NBR handshake (or on drop), never earlier.
REQ-020 EMIT_REF SHALL present out_id=ref_id, out_force=in_force unchanged, out_is_nbr=0.
REQ-021 EMIT_NBR SHALL present out_id=nbr_id, out_force per axis = sign bit inverted, out_is_nbr=1.
REQ-022 Axis with bits[30:0]==0 SHALL be emitted as +0 (all 32 bits zero) in both writes; -0 never appears on out_force.
REQ-023 Head with ref_id==nbr_id, or all three axes zero magnitude, SHALL be dropped: popped in one cycle, no output, drop_cnt+1.
REQ-024 out_* SHALL be registered; out_valid SHALL stay high and out_id/out_force/out_is_nbr stable until handshake.
REQ-025 Minimum latency: record accepted at edge T into empty FIFO -> EMIT_REF out_valid high after edge T+1.
REQ-026 Sustained throughput with out_ready=1: one pair per 2 cycles, no bubbles between pairs.
REQ-027 Simultaneous push and pop when full SHALL NOT occur (in_ready=0 when full); push and pop in same cycle otherwise both take effect.
REQ-028 pair_cnt increments on EMIT_NBR handshake; counters wrap modulo 2^32.

Reset
REQ-029 On rst_n low: FSM=IDLE, FIFO empty, in_ready=0 while asserted, out_valid=0, out_id=0, out_force=0, out_is_nbr=0, pair_cnt=0, drop_cnt=0.
REQ-030 Reset mid-pair SHALL discard the pair; no neighbor write for it is emitted after release.
REQ-031 in_ready SHALL rise the first edge after rst_n deasserts.

Structure
REQ-032 Shared package md_pkg SHALL hold the 96-bit vec3 type, axis offsets, float sign-bit index (31) and the zero-magnitude predicate.
REQ-033 FIFO SHALL be a sub-module pair_fifo (DEPTH, payload 2*ID_W+96); FSM and negation stay in n3l_reaction.

Verification
REQ-034 Push (ref=3, nbr=7, force x=0x3F800000 y=0xC0000000 z=0), out_ready=1 -> (3,0x3F800000,0xC0000000,0,nbr=0) then (7,0xBF800000,0x40000000,0,nbr=1); pair_cnt=1.
REQ-035 Push ref=5,nbr=5 and separately force all 0x80000000 -> no out_valid, drop_cnt=2.
REQ-036 Hold out_ready=0 for 10 cycles, push 6 pairs -> in_ready low after 4, outputs stable; release -> 8 writes in order, ref/nbr alternating.
REQ-037 Back-to-back pairs, out_ready=1 -> out_valid continuously high, 2 writes per pair, 100 pairs in 200+1 cycles.
REQ-038 Assert rst_n low after EMIT_REF handshake of pair ref=1,nbr=2 -> no write to id 2; all outputs and counters 0.
